// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin snoopy bus arbiter and transaction sequencer
//
// Collects BusRd/BusRdX/BusUpgr requests from N cache controllers, grants one
// at a time in round-robin order, broadcasts a one-cycle snoop, samples the
// shared/flush responses, then sequences write-back or memory read and returns
// done plus the shared (C) indication to the requester.
//
// Ports:
//   clk_i            bus clock, rising edge
//   rstb_i           asynchronous active-high reset
//   req_valid_i[N]   per-cache request, held until its done pulse
//   req_op_i[2N]     per-cache op: 01 BusRd, 10 BusRdX, 11 BusUpgr
//   shared_i[N]      snooper holds the line (M/E/S), sampled in RESP
//   flush_i[N]       snooper flushes modified data, sampled in RESP
//   flush_data_i     per-cache flush data, MEM_W bits each
//   mem_ack_i        memory completion for mem_rd_o / mem_wr_o
//   mem_rdata_i      memory read data, valid with mem_ack_i in MEM_RD
//   grant_o[N]       one-hot bus owner, SNOOP through DONE
//   snoop_valid_o    one-cycle snoop strobe
//   snoop_op_o       op being snooped
//   snoop_src_o      index of the requester
//   c_out_o          shared indication, valid with done_o
//   done_o[N]        one-cycle completion pulse
//   rdata_o          line data returned to the requester
//   mem_rd_o/mem_wr_o  memory read / write-back request, held until mem_ack_i
//   mem_wdata_o      flush data being written back
//   protocol_err_o   sticky protocol error flag
module snoop_bus_arbiter #(
   parameter int N     = 4,
   parameter int MEM_W = 32,
   localparam int SRC_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk_i,
   input  logic               rstb_i,
   input  logic [N-1:0]       req_valid_i,
   input  logic [2*N-1:0]     req_op_i,
   input  logic [N-1:0]       shared_i,
   input  logic [N-1:0]       flush_i,
   input  logic [N*MEM_W-1:0] flush_data_i,
   input  logic               mem_ack_i,
   input  logic [MEM_W-1:0]   mem_rdata_i,
   output logic [N-1:0]       grant_o,
   output logic               snoop_valid_o,
   output logic [1:0]         snoop_op_o,
   output logic [SRC_W-1:0]   snoop_src_o,
   output logic               c_out_o,
   output logic [N-1:0]       done_o,
   output logic [MEM_W-1:0]   rdata_o,
   output logic               mem_rd_o,
   output logic               mem_wr_o,
   output logic [MEM_W-1:0]   mem_wdata_o,
   output logic               protocol_err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_SNOOP, S_RESP, S_WB, S_MEM_RD, S_DONE
   } state_t;

   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_UPGR = 2'b11;

   state_t             state_q;
   logic [SRC_W-1:0]   rr_ptr_q;
   logic [1:0]         op_q;
   logic               shared_q;
   logic [N-1:0]       grant_q;
   logic               snoop_valid_q;
   logic [1:0]         snoop_op_q;
   logic [SRC_W-1:0]   snoop_src_q;
   logic               c_out_q;
   logic [N-1:0]       done_q;
   logic [MEM_W-1:0]   rdata_q;
   logic               mem_rd_q;
   logic               mem_wr_q;
   logic [MEM_W-1:0]   mem_wdata_q;
   logic               err_q;

   logic               win_found_d;
   logic [SRC_W-1:0]   win_idx_d;
   logic [1:0]         win_op_d;
   logic [N-1:0]       shared_m;
   logic [N-1:0]       flush_m;
   logic [MEM_W-1:0]   flush_sel_d;
   logic               flush_multi_d;
   int unsigned        j;

   // Round-robin search starting at rr_ptr_q; first requester found wins.
   always_comb begin
      win_found_d = 1'b0;
      win_idx_d   = '0;
      win_op_d    = 2'b00;
      j           = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(rr_ptr_q) + i;
         if (j >= N) j = j - N;
         if (!win_found_d && req_valid_i[j]) begin
            win_found_d = 1'b1;
            win_idx_d   = SRC_W'(j);
            win_op_d    = req_op_i[2*j +: 2];
         end
      end
   end

   // grant_q is the one-hot of the requester, so it doubles as the self-mask.
   assign shared_m      = shared_i & ~grant_q;
   assign flush_m       = flush_i & ~grant_q;
   assign flush_multi_d = |(flush_m & (flush_m - N'(1)));

   // Descending scan so the lowest flushing index ends up selected.
   always_comb begin
      flush_sel_d = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (flush_m[i]) flush_sel_d = flush_data_i[i*MEM_W +: MEM_W];
      end
   end

   always_ff @(posedge clk_i or posedge rstb_i) begin
      if (rstb_i) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         op_q          <= 2'b00;
         shared_q      <= 1'b0;
         grant_q       <= '0;
         snoop_valid_q <= 1'b0;
         snoop_op_q    <= 2'b00;
         snoop_src_q   <= '0;
         c_out_q       <= 1'b0;
         done_q        <= '0;
         rdata_q       <= '0;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_wdata_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_found_d) begin
                  state_q       <= S_SNOOP;
                  grant_q       <= N'(1) << win_idx_d;
                  snoop_valid_q <= 1'b1;
                  snoop_op_q    <= win_op_d;
                  snoop_src_q   <= win_idx_d;
                  // An illegal 00 op is flagged and carried on as BusRd.
                  op_q          <= (win_op_d == 2'b00) ? OP_RD : win_op_d;
                  if (win_op_d == 2'b00) err_q <= 1'b1;
                  rr_ptr_q      <= (win_idx_d == SRC_W'(N - 1)) ? '0 : win_idx_d + SRC_W'(1);
               end
            end
            S_SNOOP: begin
               snoop_valid_q <= 1'b0;
               state_q       <= S_RESP;
            end
            S_RESP: begin
               shared_q <= |shared_m;
               if (|flush_m) begin
                  if (flush_multi_d || op_q == OP_UPGR) err_q <= 1'b1;
                  mem_wdata_q <= flush_sel_d;
                  mem_wr_q    <= 1'b1;
                  state_q     <= S_WB;
               end else if (op_q == OP_UPGR) begin
                  done_q  <= grant_q;
                  c_out_q <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  mem_rd_q <= 1'b1;
                  state_q  <= S_MEM_RD;
               end
            end
            S_WB: begin
               if (mem_ack_i) begin
                  mem_wr_q <= 1'b0;
                  // Cache-to-cache supply: the flushed line is the answer.
                  if (op_q != OP_UPGR) rdata_q <= mem_wdata_q;
                  done_q   <= grant_q;
                  c_out_q  <= (op_q == OP_RD) && shared_q;
                  state_q  <= S_DONE;
               end
            end
            S_MEM_RD: begin
               if (mem_ack_i) begin
                  mem_rd_q <= 1'b0;
                  rdata_q  <= mem_rdata_i;
                  done_q   <= grant_q;
                  c_out_q  <= (op_q == OP_RD) && shared_q;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= '0;
               c_out_q <= 1'b0;
               grant_q <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant_o        = grant_q;
   assign snoop_valid_o  = snoop_valid_q;
   assign snoop_op_o     = snoop_op_q;
   assign snoop_src_o    = snoop_src_q;
   assign c_out_o        = c_out_q;
   assign done_o         = done_q;
   assign rdata_o        = rdata_q;
   assign mem_rd_o       = mem_rd_q;
   assign mem_wr_o       = mem_wr_q;
   assign mem_wdata_o    = mem_wdata_q;
   assign protocol_err_o = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - directed self-checking bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;
   localparam int N     = 4;
   localparam int MEM_W = 32;

   logic               clk = 1'b0;
   logic               rstb;
   logic [N-1:0]       req_valid;
   logic [2*N-1:0]     req_op;
   logic [N-1:0]       shared_in;
   logic [N-1:0]       flush_in;
   logic [N*MEM_W-1:0] flush_data;
   logic               mem_ack;
   logic [MEM_W-1:0]   mem_rdata;
   logic [N-1:0]       grant;
   logic               snoop_valid;
   logic [1:0]         snoop_op;
   logic [1:0]         snoop_src;
   logic               c_out;
   logic [N-1:0]       done;
   logic [MEM_W-1:0]   rdata;
   logic               mem_rd;
   logic               mem_wr;
   logic [MEM_W-1:0]   mem_wdata;
   logic               protocol_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int snoop_cnt = 0;
   int rd_seen = 0;
   int wr_seen = 0;
   logic [1:0] last_src = '0;
   int src_q[$];
   int cyc_q[$];

   snoop_bus_arbiter #(.N(N), .MEM_W(MEM_W)) dut (
      .clk_i(clk), .rstb_i(rstb), .req_valid_i(req_valid), .req_op_i(req_op),
      .shared_i(shared_in), .flush_i(flush_in), .flush_data_i(flush_data),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .grant_o(grant),
      .snoop_valid_o(snoop_valid), .snoop_op_o(snoop_op), .snoop_src_o(snoop_src),
      .c_out_o(c_out), .done_o(done), .rdata_o(rdata), .mem_rd_o(mem_rd),
      .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata), .protocol_err_o(protocol_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (snoop_valid) begin
         snoop_cnt++;
         last_src = snoop_src;
         src_q.push_back(int'(snoop_src));
         cyc_q.push_back(cyc);
      end
      if (mem_rd) rd_seen++;
      if (mem_wr) wr_seen++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // which: 0 mem_rd, 1 mem_wr, 2 any done, 3 snoop seen
   task automatic wait_for(input int which, input string tag);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         case (which)
            0: hit = mem_rd;
            1: hit = mem_wr;
            2: hit = |done;
            default: hit = (src_q.size() > 0);
         endcase
      end
      chk(tag, 64'(hit), 64'd1);
   endtask

   task automatic clr_mon();
      snoop_cnt = 0; rd_seen = 0; wr_seen = 0;
      src_q.delete(); cyc_q.delete();
   endtask

   initial begin
      rstb = 1'b1; req_valid = '0; req_op = '0; shared_in = '0; flush_in = '0;
      flush_data = '0; mem_ack = 1'b0; mem_rdata = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 64'(grant), 0);
      chk("rst_snoop", 64'(snoop_valid), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_memrw", 64'({mem_rd, mem_wr}), 0);
      chk("rst_rdata", 64'(rdata), 0);
      chk("rst_err", 64'(protocol_err), 0);
      @(posedge clk); #1 rstb = 1'b0;

      // 1: BusRd from cache 1, no sharers, mem_ack 3 cycles after mem_rd
      @(posedge clk); #1;
      clr_mon();
      req_valid = 4'b0010; req_op = 8'b0000_0100;
      wait_for(0, "t1_mem_rd");
      @(posedge clk); @(negedge clk);
      chk("t1_mem_rd_held", 64'(mem_rd), 1);
      @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
      @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk);
      chk("t1_done", 64'(done), 4'b0010);
      chk("t1_c_out", 64'(c_out), 0);
      chk("t1_rdata", 64'(rdata), 32'hA5A5A5A5);
      chk("t1_snoop_cnt", 64'(snoop_cnt), 1);
      chk("t1_snoop_src", 64'(last_src), 1);
      chk("t1_no_wr", 64'(wr_seen), 0);
      @(posedge clk); #1 req_valid = '0; req_op = '0;

      // 2: BusRd from cache 0, cache 2 shares and flushes
      @(posedge clk); #1;
      clr_mon();
      req_valid = 4'b0001; req_op = 8'b0000_0001;
      shared_in = 4'b0100; flush_in = 4'b0100;
      flush_data[2*MEM_W +: MEM_W] = 32'h1234; mem_rdata = 32'hDEAD;
      wait_for(1, "t2_mem_wr");
      chk("t2_wdata", 64'(mem_wdata), 32'h1234);
      @(posedge clk); #1 mem_ack = 1'b1;
      @(posedge clk); #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("t2_done", 64'(done), 4'b0001);
      chk("t2_c_out", 64'(c_out), 1);
      chk("t2_rdata", 64'(rdata), 32'h1234);
      chk("t2_no_rd", 64'(rd_seen), 0);
      chk("t2_err", 64'(protocol_err), 0);
      @(posedge clk); #1 req_valid = '0; req_op = '0; shared_in = '0; flush_in = '0;
      flush_data = '0; mem_rdata = '0;

      // 3: BusUpgr from cache 3, no flush, done at t+3
      @(posedge clk); #1;
      clr_mon();
      req_valid = 4'b1000; req_op = 8'b1100_0000; shared_in = 4'b0001;
      @(posedge clk); @(negedge clk);
      chk("t3_snoop", 64'({snoop_valid, snoop_op, snoop_src}), 5'b1_11_11);
      chk("t3_grant", 64'(grant), 4'b1000);
      @(posedge clk); @(negedge clk);
      chk("t3_no_early_done", 64'(done), 0);
      @(posedge clk); @(negedge clk);
      chk("t3_done", 64'(done), 4'b1000);
      chk("t3_c_out", 64'(c_out), 0);
      chk("t3_no_mem", 64'(rd_seen + wr_seen), 0);
      @(posedge clk); #1 req_valid = '0; req_op = '0; shared_in = '0;
      @(negedge clk);
      chk("t3_grant_drop", 64'(grant), 0);

      // 4: all four request from reset, round-robin with one IDLE between
      rstb = 1'b1;
      req_valid = 4'b1111; req_op = 8'b1111_1111;
      @(posedge clk); #1 rstb = 1'b0;
      clr_mon();
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (src_q.size() >= 5) break;
      end
      chk("t4_count", 64'(src_q.size() >= 5), 1);
      if (src_q.size() >= 5) begin
         chk("t4_src0", 64'(src_q[0]), 0);
         chk("t4_src1", 64'(src_q[1]), 1);
         chk("t4_src2", 64'(src_q[2]), 2);
         chk("t4_src3", 64'(src_q[3]), 3);
         chk("t4_src4", 64'(src_q[4]), 0);
         for (int k = 0; k < 4; k++) chk("t4_gap", 64'(cyc_q[k+1] - cyc_q[k]), 4);
      end
      @(posedge clk); #1 req_valid = '0; req_op = '0;
      repeat (8) @(posedge clk);

      // 5: two flushers, ack already high before WB
      #1;
      @(negedge clk);
      chk("t5_err_pre", 64'(protocol_err), 0);
      @(posedge clk); #1;
      req_valid = 4'b0001; req_op = 8'b0000_0001; mem_ack = 1'b1;
      shared_in = 4'b0110; flush_in = 4'b0110;
      flush_data[1*MEM_W +: MEM_W] = 32'h1111;
      flush_data[2*MEM_W +: MEM_W] = 32'h2222;
      wait_for(1, "t5_mem_wr");
      chk("t5_wdata", 64'(mem_wdata), 32'h1111);
      chk("t5_err", 64'(protocol_err), 1);
      wait_for(2, "t5_done_seen");
      chk("t5_done", 64'(done), 4'b0001);
      chk("t5_rdata", 64'(rdata), 32'h1111);
      @(posedge clk); #1 req_valid = '0; req_op = '0; mem_ack = 1'b0;
      shared_in = '0; flush_in = '0; flush_data = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t5_err_sticky", 64'(protocol_err), 1);

      // 6: reset during MEM_RD, then rr_ptr restarts at 0
      @(posedge clk); #1;
      req_valid = 4'b0010; req_op = 8'b0000_0100;
      wait_for(0, "t6_mem_rd");
      #1 rstb = 1'b1;
      #1;
      chk("t6_grant_async", 64'(grant), 0);
      chk("t6_mem_rd_async", 64'(mem_rd), 0);
      chk("t6_done_async", 64'(done), 0);
      chk("t6_err_cleared", 64'(protocol_err), 0);
      req_valid = 4'b1010; req_op = 8'b0100_0100;
      @(posedge clk); #1 rstb = 1'b0;
      clr_mon();
      wait_for(3, "t6_snoop_seen");
      if (src_q.size() > 0) chk("t6_first_src", 64'(src_q[0]), 1);
      wait_for(0, "t6_mem_rd2");
      #1 mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      @(posedge clk); #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("t6_done", 64'(done), 4'b0010);
      chk("t6_rdata", 64'(rdata), 32'h0BADF00D);
      @(posedge clk); #1 req_valid = '0; req_op = '0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
